// File: rtl/serial_alu_pkg.sv
// Shared definitions for serial_alu: op codes, op field width and FSM states.
package serial_alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_INV = 3'b000;
    localparam logic [OP_W-1:0] OP_OR  = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_XOR = 3'b011;
    localparam logic [OP_W-1:0] OP_ADD = 3'b100;
    localparam logic [OP_W-1:0] OP_SUB = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_alu_digit.sv
// One DIGIT_W-wide slice of the serial ALU. Purely combinational.
// SUB support is compiled only when SERIAL_ALU_SUB_EN is defined.
module serial_alu_digit
    import serial_alu_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic [DIGIT_W-1:0] a_d,
    input  logic [DIGIT_W-1:0] b_d,
    input  logic [OP_W-1:0]    op,
    input  logic               cin,
    output logic [DIGIT_W-1:0] y_d,
    output logic               cout
);

    logic [DIGIT_W:0] sum;

    // Select the digit result; reserved ops yield zero with no carry.
    always_comb begin
        sum  = '0;
        y_d  = '0;
        cout = 1'b0;
        case (op)
            OP_INV: y_d = ~a_d;
            OP_OR:  y_d = a_d | b_d;
            OP_AND: y_d = a_d & b_d;
            OP_XOR: y_d = a_d ^ b_d;
            OP_ADD: begin
                sum  = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT_W{1'b0}}, cin};
                y_d  = sum[DIGIT_W-1:0];
                cout = sum[DIGIT_W];
            end
`ifdef SERIAL_ALU_SUB_EN
            OP_SUB: begin
                // a - b as a + ~b; the +1 arrives through the carry seeded at start.
                sum  = {1'b0, a_d} + {1'b0, ~b_d} + {{DIGIT_W{1'b0}}, cin};
                y_d  = sum[DIGIT_W-1:0];
                cout = sum[DIGIT_W];
            end
`endif
            default: begin
                y_d  = '0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu.sv
// serial_alu: multi-cycle bitwise/add unit processing DIGIT_W bits per clock,
// LSB digit first, carry held between cycles.
// Optional macro SERIAL_ALU_SUB_EN enables op 101 = SUB (a - b).
//
// Handshake: start is sampled only when busy is low (IDLE or DONE). An accepted
// start latches a/b/op; busy is high for the N digit cycles that follow; done
// pulses for exactly one cycle with y/co valid. start while busy is dropped.
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DIGIT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             co,
    output state_t           state_dbg
);

    localparam int N     = WIDTH / DIGIT_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [OP_W-1:0]    op_q;
    logic [DIGIT_W-1:0] y_d;
    logic               cout;
    logic               accept;
    logic               last;

    assign accept    = start && (state != RUN);
    assign last      = (cnt == CNT_W'(N - 1));
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign state_dbg = state;

    serial_alu_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .a_d  (a_q[int'(cnt)*DIGIT_W +: DIGIT_W]),
        .b_d  (b_q[int'(cnt)*DIGIT_W +: DIGIT_W]),
        .op   (op_q),
        .cin  (carry),
        .y_d  (y_d),
        .cout (cout)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state: DONE accepts a new start just like IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, digit counter, carry chain and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            y     <= '0;
            co    <= 1'b0;
        end else if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
            cnt  <= '0;
            co   <= 1'b0;
`ifdef SERIAL_ALU_SUB_EN
            carry <= (op == OP_SUB);
`else
            carry <= 1'b0;
`endif
        end else if (state == RUN) begin
            y[int'(cnt)*DIGIT_W +: DIGIT_W] <= y_d;
            carry <= cout;
            if (last) begin
                // Non-arithmetic ops always produce cout=0, so co stays 0 for them.
                co  <= cout;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu (WIDTH=8, DIGIT_W=4).
module tb_serial_alu;
    import serial_alu_pkg::*;

    localparam int WIDTH   = 8;
    localparam int DIGIT_W = 4;
    localparam int N       = WIDTH / DIGIT_W;
    localparam int EXP_W   = WIDTH + 1;
    localparam int MAX_WAIT = 20;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y;
    logic             co;
    state_t           state_dbg;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: expected {co, y} of each accepted operation, in order.
    logic [EXP_W-1:0] exp_q[$];

    serial_alu #(
        .WIDTH   (WIDTH),
        .DIGIT_W (DIGIT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .y         (y),
        .co        (co),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Whole-word arithmetic; the bit above WIDTH is the carry out.
    function automatic logic [EXP_W-1:0] model(input logic [OP_W-1:0] m_op,
                                               input logic [WIDTH-1:0] m_a,
                                               input logic [WIDTH-1:0] m_b);
        case (m_op)
            3'd0: return {1'b0, ~m_a};
            3'd1: return {1'b0, m_a | m_b};
            3'd2: return {1'b0, m_a & m_b};
            3'd3: return {1'b0, m_a ^ m_b};
            3'd4: return EXP_W'(m_a) + EXP_W'(m_b);
`ifdef SERIAL_ALU_SUB_EN
            // co=1 exactly when no borrow, i.e. a >= b.
            3'd5: return {(m_a >= m_b), WIDTH'(m_a - m_b)};
`endif
            default: return '0;
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Called at a negedge. Presents a start, pushes the expected result and
    // returns at the negedge after the accept edge, with inputs scrambled.
    task automatic launch(input logic [OP_W-1:0] l_op, input logic [WIDTH-1:0] l_a,
                          input logic [WIDTH-1:0] l_b, input logic [EXP_W-1:0] l_exp);
        start = 1'b1;
        op    = l_op;
        a     = l_a;
        b     = l_b;
        exp_q.push_back(l_exp);
        @(negedge clk);
        start = 1'b0;
        op    = OP_W'($urandom_range(0, 7));
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        check("busy_after_accept", 32'(busy), 32'd1);
        check("no_done_after_accept", 32'(done), 32'd0);
    endtask

    // Waits (bounded) for done; n0 negedges after the accept edge have already
    // elapsed. Returns at the negedge inside the done cycle.
    task automatic finish_op(input string tag, input int n0);
        int n;
        logic [EXP_W-1:0] e;
        n = n0;
        while (!done && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(N));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        if (exp_q.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_y"}, 32'(y), 32'(e[WIDTH-1:0]));
            check({tag, "_co"}, 32'(co), 32'(e[WIDTH]));
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op      = '0;
        a       = '0;
        b       = '0;

        // Reset with random activity on the inputs.
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            op    = OP_W'($urandom_range(0, 7));
            a     = WIDTH'($urandom);
            b     = WIDTH'($urandom);
            @(negedge clk);
            check("rst_y", 32'(y), 32'd0);
            check("rst_co", 32'(co), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
        end
        start   = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_y", 32'(y), 32'd0);
            check("idle_busy_done", {30'd0, busy, done}, 32'd0);
        end

        // ADD with carry out, then single done pulse and y hold.
        launch(OP_ADD, 8'hF0, 8'h1F, {1'b1, 8'h0F});
        finish_op("add", 0);
        @(negedge clk);
        check("add_done_one_cycle", 32'(done), 32'd0);
        check("add_y_hold", 32'(y), 32'h0F);

        // Logic ops.
        launch(OP_XOR, 8'hA5, 8'h0F, {1'b0, 8'hAA});
        finish_op("xor", 0);
        @(negedge clk);
        launch(OP_INV, 8'h3C, 8'h5A, {1'b0, 8'hC3});
        finish_op("inv", 0);
        @(negedge clk);
        launch(OP_AND, 8'hF3, 8'h3F, {1'b0, 8'h33});
        finish_op("and", 0);
        @(negedge clk);
        launch(OP_OR, 8'h50, 8'h05, {1'b0, 8'h55});
        finish_op("or", 0);
        @(negedge clk);

        // Start while busy is ignored.
        launch(OP_ADD, 8'h01, 8'h01, {1'b0, 8'h02});
        start = 1'b1;
        op    = OP_XOR;
        a     = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        finish_op("ignored_start", 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ignored_no_second_op", {30'd0, busy, done}, 32'd0);
        end

        // Start in the DONE cycle goes straight back to RUN.
        launch(OP_ADD, 8'hF0, 8'h1F, {1'b1, 8'h0F});
        finish_op("b2b_first", 0);
        launch(OP_XOR, 8'hA5, 8'h0F, {1'b0, 8'hAA});
        finish_op("b2b_second", 0);
        @(negedge clk);

        // Asynchronous reset in the middle of RUN.
        launch(OP_ADD, 8'h77, 8'h77, {1'b0, 8'hEE});
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("abort_y", 32'(y), 32'd0);
        check("abort_co", 32'(co), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        launch(OP_ADD, 8'h33, 8'h44, {1'b0, 8'h77});
        finish_op("post_reset_add", 0);
        @(negedge clk);

        // Op 101 and reserved codes.
`ifdef SERIAL_ALU_SUB_EN
        launch(OP_SUB, 8'h05, 8'h07, {1'b0, 8'hFE});
        finish_op("sub_borrow", 0);
        @(negedge clk);
        launch(OP_SUB, 8'h07, 8'h05, {1'b1, 8'h02});
        finish_op("sub_no_borrow", 0);
        @(negedge clk);
`else
        launch(OP_SUB, 8'hFF, 8'hFF, {1'b0, 8'h00});
        finish_op("op101_reserved", 0);
        @(negedge clk);
`endif
        launch(3'b110, 8'hFF, 8'hFF, {1'b0, 8'h00});
        finish_op("op110_reserved", 0);
        @(negedge clk);

        // Randomized operations against the model, sometimes back-to-back.
        for (int i = 0; i < 30; i++) begin
            logic [OP_W-1:0]  r_op;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            r_op = OP_W'($urandom_range(0, 7));
            r_a  = WIDTH'($urandom);
            r_b  = WIDTH'($urandom);
            launch(r_op, r_a, r_b, model(r_op, r_a, r_b));
            finish_op("rand", 0);
            if ($urandom_range(0, 1) == 0) begin
                @(negedge clk);
                check("rand_done_pulse", 32'(done), 32'd0);
            end
        end

        // Final report.
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_alu.md
Name: serial_alu

Overview:
- Parametrised, multi-cycle successor to the team's single-bit 2-input gate cells (INV/OR/AND/XOR).
- Applies a selectable bitwise or add operation to WIDTH-bit operands, DIGIT_W bits per clock, LSB digit first.
- Carry is held between cycles.
- Uses a start/busy/done handshake; sits beside datapath blocks needing area-cheap wide logic/add.

Parameters:
- WIDTH, 8, operand/result width; must be a multiple of DIGIT_W.
- DIGIT_W, 4, bits processed per clock.
- Derived (localparam): N = WIDTH/DIGIT_W digits. The counter is sized so it can hold N-1 (minimum 1 bit).

Ports:
- clk, input, 1, single clock; rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, request; sampled only when not busy.
- op, input, 3, operation code, latched on accepted start.
- a, input, WIDTH, operand A, latched on accepted start.
- b, input, WIDTH, operand B, latched on accepted start.
- busy, output, 1, high while digits are being processed.
- done, output, 1, one-cycle pulse: y/co valid.
- y, output, WIDTH, result register.
- co, output, 1, final carry out (ADD/SUB only, else 0).

Behaviour:
- Op codes: 000 INV (y=~a, b ignored), 001 OR, 010 AND, 011 XOR, 100 ADD (y=a+b mod 2^WIDTH, co=carry out of MSB).
- Op 101 is reserved unless the optional feature is enabled. Ops 110/111 are reserved.
- Reserved ops run the full N cycles and produce y=0, co=0.
- Reset (reset_n=0, asynchronous, any state): state=IDLE, busy=0, done=0, y=0, co=0, counter=0, carry=0, latched operands=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch a, b, op; counter=0; carry=0 (1 for SUB); go to RUN. busy goes high after that edge.
- RUN:
  - Each edge computes digit[counter] from the latched operands and carry, writes it into y[counter*DIGIT_W +: DIGIT_W], updates carry, and increments counter.
  - The edge that processes digit N-1 sets co (ADD/SUB only) and goes to DONE.
  - busy=1 throughout RUN.
- DONE:
  - busy=0, done=1 for exactly one cycle, then IDLE. Next edge: IDLE, done=0.
  - start=1 in DONE is accepted exactly as in IDLE: new operands are latched and the state goes directly to RUN; done still deasserts.
- Latency: the start-accept edge is edge 0. Digit processing occupies edges 1..N. done is high in the cycle following edge N.
- Back-to-back throughput: one result per N+1 cycles.
- start while busy=1 is ignored; operands are not re-latched and there is no queuing.
- Changes on a/b/op after acceptance have no effect on the result.
- y holds its last value from DONE until the next accepted start.
- During RUN, y bits not yet written hold the previous result. Only the value at done is defined.
- co is cleared to 0 on an accepted start and written at the last digit.
- Asynchronous reset mid-RUN aborts the operation: no done pulse, outputs 0 immediately.

Optional Feature:
- Macro: SERIAL_ALU_SUB_EN.
- Defined: op 101 = SUB; y = a - b mod 2^WIDTH, computed as a + ~b with carry initialised to 1. co=1 means no borrow (a >= b unsigned).
- Undefined: op 101 is reserved (y=0, co=0); the SUB carry-init logic is not compiled.

Decomposition:
- Shared package:
  - op code constants (OP_INV, OP_OR, OP_AND, OP_XOR, OP_ADD, OP_SUB);
  - FSM state typedef (IDLE/RUN/DONE);
  - op field width constant.
- One sub-module, serial_alu_digit: purely combinational DIGIT_W-wide slice with inputs a_d, b_d, op, cin and outputs y_d, cout. Instantiated once; the top holds FSM, counter, carry and result registers.

Test Plan (WIDTH=8, DIGIT_W=4, N=2):
- Reset: hold reset_n=0 with random inputs -> y=8'h00, co=0, busy=0, done=0; release, no start -> outputs stay 0.
- ADD: a=8'hF0, b=8'h1F, op=100, start pulse -> busy high edges 1-2, done high one cycle after edge 2, y=8'h0F, co=1.
- Logic ops: XOR a=8'hA5 b=8'h0F -> y=8'hAA co=0; INV a=8'h3C -> y=8'hC3; AND 8'hF3&8'h3F -> 8'h33; OR 8'h50|8'h05 -> 8'h55.
- Ignored start: accept ADD 8'h01+8'h01, then assert start with op=011, a=8'hFF one cycle later -> single done, y=8'h02. Start in DONE cycle -> immediate RUN with new operands, result correct.
- Reset mid-RUN: drop reset_n during edge 1 of an ADD -> y=0, busy=0 asynchronously, no done ever pulses. Post-reset op runs normally.
- Macro: with SERIAL_ALU_SUB_EN, 8'h05-8'h07 -> y=8'hFE, co=0; 8'h07-8'h05 -> y=8'h02, co=1. Without macro, op=101 -> y=8'h00, co=0, done after N+1 cycles.
